// File: rtl/pipeline_control_unit.sv
// Control path for the 5-stage RV32I pipeline: ID decode, ID/EX -> EX/MEM -> MEM/WB
// control registers, load-use interlock, branch/jump flush and external-stall freeze.

package alu_pkg;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
endpackage

module pipeline_control_unit #(
  parameter int ALU_OP_W       = 4,
  parameter int EXT_ALU        = 1,
  parameter int LOAD_USE_STALL = 1,
  parameter int REG_ADDR_W     = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [31:0]           id_instr,
  input  logic                  stall_ext,
  input  logic                  branch_taken_ex,
  output logic                  hazard_stall,
  output logic                  flush_if_id,
  output logic                  illegal_instr,
  output logic                  ex_valid,
  output logic                  ex_reg_write,
  output logic                  ex_alu_src,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_branch,
  output logic                  ex_jump,
  output logic                  ex_jalr,
  output logic                  ex_mem_to_reg,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [REG_ADDR_W-1:0] ex_rs1,
  output logic [REG_ADDR_W-1:0] ex_rs2,
  output logic                  mem_valid,
  output logic                  mem_reg_write,
  output logic                  mem_mem_read,
  output logic                  mem_mem_write,
  output logic                  mem_mem_to_reg,
  output logic [REG_ADDR_W-1:0] mem_rd,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_rd
);
  import alu_pkg::*;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  alu_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  branch;
    logic                  jump;
    logic                  jalr;
    logic                  mem_to_reg;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [REG_ADDR_W-1:0] rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
  } idex_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } exmem_t;

  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic                  mem_to_reg;
    logic [REG_ADDR_W-1:0] rd;
  } memwb_t;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic [REG_ADDR_W-1:0] rd_f;
  logic [REG_ADDR_W-1:0] rs1_f;
  logic [REG_ADDR_W-1:0] rs2_f;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];
  assign rd_f   = REG_ADDR_W'(id_instr[11:7]);
  assign rs1_f  = REG_ADDR_W'(id_instr[19:15]);
  assign rs2_f  = REG_ADDR_W'(id_instr[24:20]);

  idex_t  dec;
  idex_t  idex_q;
  idex_t  idex_next;
  exmem_t exmem_q;
  memwb_t memwb_q;
  logic   dec_illegal;
  logic   uses_rs1;
  logic   uses_rs2;
  logic   has_rd;
  logic   illegal_q;
  logic   illegal_next;
  logic   flush_pending;
  logic   flush_raw;
  logic   flush;
  logic   load_use;
  logic [3:0] f3_op;
  logic [3:0] op;

  // Shared funct3 -> ALU op table; funct7 only matters for the right shifts here.
  always_comb begin
    f3_op = ALU_ADD;
    case (funct3)
      3'b000:  f3_op = ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  end

  always_comb begin
    dec         = '0;
    dec_illegal = 1'b0;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    has_rd      = 1'b0;
    op          = ALU_ADD;
    case (opcode)
      OPC_R: begin
        dec.reg_write = 1'b1;
        has_rd        = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
        op = (funct3 == 3'b000 && funct7 == 7'b0100000) ? ALU_SUB : f3_op;
      end
      OPC_I: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        has_rd        = 1'b1;
        uses_rs1      = 1'b1;
        op            = f3_op;
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        has_rd         = 1'b1;
        uses_rs1       = 1'b1;
      end
      OPC_STORE: begin
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_BRANCH: begin
        dec.branch = 1'b1;
        uses_rs1   = 1'b1;
        uses_rs2   = 1'b1;
        op         = ALU_SUB;
      end
      OPC_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        has_rd        = 1'b1;
      end
      OPC_JALR: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
        dec.jalr      = 1'b1;
        dec.alu_src   = 1'b1;
        has_rd        = 1'b1;
        uses_rs1      = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        has_rd        = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // The legacy ALU only implements ADD/SUB/SLL/SLT.
    if (EXT_ALU == 0 && op inside {ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND})
      op = ALU_ADD;
    if (dec_illegal) begin
      dec = '0;
    end else begin
      dec.valid     = 1'b1;
      dec.alu_op    = ALU_OP_W'(op);
      dec.rd        = has_rd ? rd_f : '0;
      dec.rs1       = uses_rs1 ? rs1_f : '0;
      dec.rs2       = uses_rs2 ? rs2_f : '0;
      dec.reg_write = dec.reg_write & has_rd & (rd_f != '0);
    end
  end

  assign flush_raw = branch_taken_ex | (idex_q.valid & idex_q.jump);
  assign flush     = flush_raw | flush_pending;
  assign load_use  = (LOAD_USE_STALL != 0) & id_valid & idex_q.valid & idex_q.mem_read &
                     (idex_q.rd != '0) &
                     ((uses_rs1 & (rs1_f == idex_q.rd)) | (uses_rs2 & (rs2_f == idex_q.rd)));

  assign hazard_stall = load_use & ~flush;
  assign flush_if_id  = flush;

  always_comb begin
    idex_next    = '0;
    illegal_next = 1'b0;
    if (!flush && !load_use && id_valid) begin
      idex_next    = dec;
      illegal_next = dec_illegal;
    end
  end

  // A flush seen while frozen is remembered and applied on the first edge that moves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         flush_pending <= 1'b0;
    else if (stall_ext) flush_pending <= flush_pending | flush_raw;
    else                flush_pending <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_q    <= '0;
      illegal_q <= 1'b0;
      exmem_q   <= '0;
      memwb_q   <= '0;
    end else if (!stall_ext) begin
      idex_q    <= idex_next;
      illegal_q <= illegal_next;
      exmem_q   <= '{valid: idex_q.valid, reg_write: idex_q.reg_write,
                     mem_read: idex_q.mem_read, mem_write: idex_q.mem_write,
                     mem_to_reg: idex_q.mem_to_reg, rd: idex_q.rd};
      memwb_q   <= '{valid: exmem_q.valid, reg_write: exmem_q.reg_write,
                     mem_to_reg: exmem_q.mem_to_reg, rd: exmem_q.rd};
    end
  end

  assign illegal_instr  = illegal_q;
  assign ex_valid       = idex_q.valid;
  assign ex_reg_write   = idex_q.reg_write;
  assign ex_alu_src     = idex_q.alu_src;
  assign ex_mem_read    = idex_q.mem_read;
  assign ex_mem_write   = idex_q.mem_write;
  assign ex_branch      = idex_q.branch;
  assign ex_jump        = idex_q.jump;
  assign ex_jalr        = idex_q.jalr;
  assign ex_mem_to_reg  = idex_q.mem_to_reg;
  assign ex_alu_op      = idex_q.alu_op;
  assign ex_rd          = idex_q.rd;
  assign ex_rs1         = idex_q.rs1;
  assign ex_rs2         = idex_q.rs2;
  assign mem_valid      = exmem_q.valid;
  assign mem_reg_write  = exmem_q.reg_write;
  assign mem_mem_read   = exmem_q.mem_read;
  assign mem_mem_write  = exmem_q.mem_write;
  assign mem_mem_to_reg = exmem_q.mem_to_reg;
  assign mem_rd         = exmem_q.rd;
  assign wb_valid       = memwb_q.valid;
  assign wb_reg_write   = memwb_q.reg_write;
  assign wb_mem_to_reg  = memwb_q.mem_to_reg;
  assign wb_rd          = memwb_q.rd;

endmodule

// File: tb/tb_pipeline_control_unit.sv
// Directed bench for pipeline_control_unit: a full-featured instance and a
// legacy instance (EXT_ALU=0, LOAD_USE_STALL=0) share the same stimulus.
module tb_pipeline_control_unit;
  import alu_pkg::*;

  localparam logic [31:0] I_ADD3  = 32'h002081B3;
  localparam logic [31:0] I_SUB   = 32'h40208133;
  localparam logic [31:0] I_SRA   = 32'h4020D1B3;
  localparam logic [31:0] I_XORI  = 32'h0050C213;
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_ADD6  = 32'h00128333;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_NOP   = 32'h00000013;

  logic clk, rst_n, id_valid, stall_ext, branch_taken_ex;
  logic [31:0] id_instr;

  logic hazard_stall, flush_if_id, illegal_instr;
  logic ex_valid, ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write;
  logic ex_branch, ex_jump, ex_jalr, ex_mem_to_reg;
  logic [3:0] ex_alu_op;
  logic [4:0] ex_rd, ex_rs1, ex_rs2, mem_rd, wb_rd;
  logic mem_valid, mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg;
  logic wb_valid, wb_reg_write, wb_mem_to_reg;

  logic l_hazard_stall, l_flush_if_id, l_illegal_instr;
  logic l_ex_valid, l_ex_reg_write, l_ex_alu_src, l_ex_mem_read, l_ex_mem_write;
  logic l_ex_branch, l_ex_jump, l_ex_jalr, l_ex_mem_to_reg;
  logic [3:0] l_ex_alu_op;
  logic [4:0] l_ex_rd, l_ex_rs1, l_ex_rs2, l_mem_rd, l_wb_rd;
  logic l_mem_valid, l_mem_reg_write, l_mem_mem_read, l_mem_mem_write, l_mem_mem_to_reg;
  logic l_wb_valid, l_wb_reg_write, l_wb_mem_to_reg;

  logic [48:0] all_out;
  logic [27:0] ex_bundle;

  int pass_cnt = 0;
  int total_cnt = 0;

  assign all_out = {hazard_stall, flush_if_id, illegal_instr, ex_valid, ex_reg_write,
                    ex_alu_src, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_jalr,
                    ex_mem_to_reg, ex_alu_op, ex_rd, ex_rs1, ex_rs2, mem_valid,
                    mem_reg_write, mem_mem_read, mem_mem_write, mem_mem_to_reg, mem_rd,
                    wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd};
  assign ex_bundle = {ex_reg_write, ex_alu_src, ex_mem_read, ex_mem_write, ex_branch,
                      ex_jump, ex_jalr, ex_mem_to_reg, ex_alu_op, ex_rd, ex_rs1, ex_rs2};

  pipeline_control_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .stall_ext(stall_ext), .branch_taken_ex(branch_taken_ex),
    .hazard_stall(hazard_stall), .flush_if_id(flush_if_id), .illegal_instr(illegal_instr),
    .ex_valid(ex_valid), .ex_reg_write(ex_reg_write), .ex_alu_src(ex_alu_src),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_jalr(ex_jalr), .ex_mem_to_reg(ex_mem_to_reg),
    .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .mem_valid(mem_valid), .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_mem_write(mem_mem_write), .mem_mem_to_reg(mem_mem_to_reg), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_rd(wb_rd)
  );

  pipeline_control_unit #(.EXT_ALU(0), .LOAD_USE_STALL(0)) u_legacy (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .stall_ext(stall_ext), .branch_taken_ex(branch_taken_ex),
    .hazard_stall(l_hazard_stall), .flush_if_id(l_flush_if_id),
    .illegal_instr(l_illegal_instr),
    .ex_valid(l_ex_valid), .ex_reg_write(l_ex_reg_write), .ex_alu_src(l_ex_alu_src),
    .ex_mem_read(l_ex_mem_read), .ex_mem_write(l_ex_mem_write), .ex_branch(l_ex_branch),
    .ex_jump(l_ex_jump), .ex_jalr(l_ex_jalr), .ex_mem_to_reg(l_ex_mem_to_reg),
    .ex_alu_op(l_ex_alu_op), .ex_rd(l_ex_rd), .ex_rs1(l_ex_rs1), .ex_rs2(l_ex_rs2),
    .mem_valid(l_mem_valid), .mem_reg_write(l_mem_reg_write),
    .mem_mem_read(l_mem_mem_read), .mem_mem_write(l_mem_mem_write),
    .mem_mem_to_reg(l_mem_mem_to_reg), .mem_rd(l_mem_rd),
    .wb_valid(l_wb_valid), .wb_reg_write(l_wb_reg_write),
    .wb_mem_to_reg(l_wb_mem_to_reg), .wb_rd(l_wb_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    id_valid = 1'b1;
    id_instr = I_ADD3;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (all_out !== '0) $display("[TB] FAIL reset_all_zero: got %h expected 0", all_out);
    else pass_cnt++;
    #2;
    rst_n = 1'b1;
    tick();
    total_cnt++;
    if (ex_alu_op !== ALU_ADD || ex_reg_write !== 1'b1 || ex_rd !== 5'd3)
      $display("[TB] FAIL reset_first_add: got op=%0d rw=%b rd=%0d expected op=0 rw=1 rd=3",
               ex_alu_op, ex_reg_write, ex_rd);
    else pass_cnt++;
    id_valid = 1'b0;
    tick(); tick();
    total_cnt++;
    if (wb_valid !== 1'b1 || wb_rd !== 5'd3 || wb_reg_write !== 1'b1)
      $display("[TB] FAIL reset_wb_latency: got v=%b rd=%0d rw=%b expected v=1 rd=3 rw=1",
               wb_valid, wb_rd, wb_reg_write);
    else pass_cnt++;
  endtask

  task automatic test_decode();
    id_valid = 1'b1;
    id_instr = I_SUB;
    tick();
    total_cnt++;
    if (ex_alu_op !== ALU_SUB || ex_rd !== 5'd2)
      $display("[TB] FAIL decode_sub: got op=%0d rd=%0d expected op=1 rd=2", ex_alu_op, ex_rd);
    else pass_cnt++;
    id_instr = I_SRA;
    tick();
    total_cnt++;
    if (ex_alu_op !== ALU_SRA)
      $display("[TB] FAIL decode_sra_ext: got %0d expected %0d", ex_alu_op, ALU_SRA);
    else pass_cnt++;
    total_cnt++;
    if (l_ex_alu_op !== ALU_ADD)
      $display("[TB] FAIL decode_sra_legacy: got %0d expected %0d", l_ex_alu_op, ALU_ADD);
    else pass_cnt++;
    id_instr = I_XORI;
    tick();
    total_cnt++;
    if (ex_alu_op !== ALU_XOR || ex_alu_src !== 1'b1 || ex_rd !== 5'd4 || ex_rs1 !== 5'd1)
      $display("[TB] FAIL decode_xori: got op=%0d src=%b rd=%0d rs1=%0d expected 5 1 4 1",
               ex_alu_op, ex_alu_src, ex_rd, ex_rs1);
    else pass_cnt++;
    total_cnt++;
    if (l_ex_alu_op !== ALU_ADD)
      $display("[TB] FAIL decode_xori_legacy: got %0d expected %0d", l_ex_alu_op, ALU_ADD);
    else pass_cnt++;
    id_instr = I_BAD;
    tick();
    total_cnt++;
    if (illegal_instr !== 1'b1 || ex_valid !== 1'b0 || ex_bundle !== '0)
      $display("[TB] FAIL decode_illegal: got ill=%b v=%b bundle=%h expected 1 0 0",
               illegal_instr, ex_valid, ex_bundle);
    else pass_cnt++;
    id_valid = 1'b0;
    tick();
    total_cnt++;
    if (illegal_instr !== 1'b0)
      $display("[TB] FAIL decode_illegal_one_cycle: got %b expected 0", illegal_instr);
    else pass_cnt++;
  endtask

  task automatic test_load_use();
    id_valid = 1'b1;
    id_instr = I_LW5;
    tick();
    id_instr = I_ADD6;
    #1;
    total_cnt++;
    if (hazard_stall !== 1'b1)
      $display("[TB] FAIL loaduse_stall_raised: got %b expected 1", hazard_stall);
    else pass_cnt++;
    total_cnt++;
    if (l_hazard_stall !== 1'b0)
      $display("[TB] FAIL loaduse_legacy_no_stall: got %b expected 0", l_hazard_stall);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0 || hazard_stall !== 1'b0 || mem_mem_read !== 1'b1 || mem_rd !== 5'd5)
      $display("[TB] FAIL loaduse_bubble: got exv=%b hs=%b mrd=%b mem_rd=%0d expected 0 0 1 5",
               ex_valid, hazard_stall, mem_mem_read, mem_rd);
    else pass_cnt++;
    total_cnt++;
    if (l_ex_valid !== 1'b1 || l_ex_rs1 !== 5'd5)
      $display("[TB] FAIL loaduse_legacy_advance: got v=%b rs1=%0d expected 1 5",
               l_ex_valid, l_ex_rs1);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_rs1 !== 5'd5 || ex_rd !== 5'd6 || ex_rs2 !== 5'd1)
      $display("[TB] FAIL loaduse_add_in_ex: got v=%b rs1=%0d rd=%0d rs2=%0d expected 1 5 6 1",
               ex_valid, ex_rs1, ex_rd, ex_rs2);
    else pass_cnt++;
    id_valid = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    id_valid = 1'b1;
    id_instr = I_ADD3;
    branch_taken_ex = 1'b1;
    #1;
    total_cnt++;
    if (flush_if_id !== 1'b1)
      $display("[TB] FAIL flush_branch_comb: got %b expected 1", flush_if_id);
    else pass_cnt++;
    tick();
    branch_taken_ex = 1'b0;
    total_cnt++;
    if (ex_valid !== 1'b0)
      $display("[TB] FAIL flush_branch_bubble: got %b expected 0", ex_valid);
    else pass_cnt++;
    id_instr = I_LW5;
    tick();
    id_instr = I_ADD6;
    branch_taken_ex = 1'b1;
    #1;
    total_cnt++;
    if (hazard_stall !== 1'b0 || flush_if_id !== 1'b1)
      $display("[TB] FAIL flush_over_loaduse: got hs=%b fl=%b expected 0 1",
               hazard_stall, flush_if_id);
    else pass_cnt++;
    tick();
    branch_taken_ex = 1'b0;
    id_instr = I_JAL;
    tick();
    id_instr = I_ADD3;
    #1;
    total_cnt++;
    if (ex_jump !== 1'b1 || flush_if_id !== 1'b1 || ex_rd !== 5'd1)
      $display("[TB] FAIL flush_jump_comb: got j=%b fl=%b rd=%0d expected 1 1 1",
               ex_jump, flush_if_id, ex_rd);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0)
      $display("[TB] FAIL flush_jump_bubble: got %b expected 0", ex_valid);
    else pass_cnt++;
  endtask

  task automatic test_ext_stall();
    id_valid = 1'b1;
    id_instr = I_ADD3; tick();
    id_instr = I_SUB;  tick();
    id_instr = I_LW5;  tick();
    id_instr = I_ADD3;
    stall_ext = 1'b1;
    tick();
    branch_taken_ex = 1'b1;
    tick();
    branch_taken_ex = 1'b0;
    tick(); tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_mem_read !== 1'b1 || ex_rd !== 5'd5 ||
        mem_valid !== 1'b1 || mem_rd !== 5'd2 || wb_valid !== 1'b1 || wb_rd !== 5'd3)
      $display("[TB] FAIL stall_hold: got ex=%b/%b/%0d mem=%b/%0d wb=%b/%0d expected 1/1/5 1/2 1/3",
               ex_valid, ex_mem_read, ex_rd, mem_valid, mem_rd, wb_valid, wb_rd);
    else pass_cnt++;
    total_cnt++;
    if (flush_if_id !== 1'b1)
      $display("[TB] FAIL stall_flush_pending: got %b expected 1", flush_if_id);
    else pass_cnt++;
    stall_ext = 1'b0;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b0 || mem_rd !== 5'd5 || mem_mem_read !== 1'b1 || wb_rd !== 5'd2)
      $display("[TB] FAIL stall_release_flush: got exv=%b mem_rd=%0d mrd=%b wb_rd=%0d expected 0 5 1 2",
               ex_valid, mem_rd, mem_mem_read, wb_rd);
    else pass_cnt++;
    total_cnt++;
    if (flush_if_id !== 1'b0)
      $display("[TB] FAIL stall_pending_clear: got %b expected 0", flush_if_id);
    else pass_cnt++;
  endtask

  task automatic test_rd_zero();
    id_valid = 1'b1;
    id_instr = I_NOP;
    tick();
    total_cnt++;
    if (ex_valid !== 1'b1 || ex_reg_write !== 1'b0 || ex_alu_src !== 1'b1 || ex_rd !== 5'd0)
      $display("[TB] FAIL rdzero_ex: got v=%b rw=%b src=%b rd=%0d expected 1 0 1 0",
               ex_valid, ex_reg_write, ex_alu_src, ex_rd);
    else pass_cnt++;
    id_valid = 1'b0;
    tick(); tick();
    total_cnt++;
    if (wb_valid !== 1'b1 || wb_reg_write !== 1'b0)
      $display("[TB] FAIL rdzero_wb: got v=%b rw=%b expected 1 0", wb_valid, wb_reg_write);
    else pass_cnt++;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0;
    id_instr = 32'h0;
    stall_ext = 1'b0;
    branch_taken_ex = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    test_reset();
    test_decode();
    test_load_use();
    test_flush();
    test_ext_stall();
    test_rd_zero();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
